// File: rtl/layer_sequencer.sv
// layer_sequencer
// Purpose: walks a chain of NUM_LAYERS processing layers (conv/relu/pool
// stages). Work on each layer is requested with a level-held begin bit. At
// most two layers are in flight: the oldest unretired layer (head) and the
// one after it. Layers retire in order. A layer that finishes early waits as
// "pending" until head completes, and then both retire together.
//
// Parameters:
//   NUM_LAYERS     number of chained layers, 2..8 (default 6)
//   TIMEOUT_CYCLES watchdog limit in cycles between retires (default 50000)
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle request to run the network once
//   layer_complete bit k = complete flag from layer k
//   layer_begin    bit k = level-held begin for layer k (registered)
//   busy           high while running (registered)
//   cur_layer      index of the head layer while running, else 0 (registered)
//   net_done       one-cycle pulse when the last layer retires (registered)
//   timeout_err    sticky watchdog error flag (registered)
//
// Optional feature: define LAYER_TIMEOUT_EN to build the 16-bit watchdog and
// the ERR state. Without it, timeout_err is tied low and ERR is unreachable.

module layer_sequencer #(
  parameter int          NUM_LAYERS     = 6,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_complete,
  output logic [NUM_LAYERS-1:0] layer_begin,
  output logic                  busy,
  output logic [2:0]            cur_layer,
  output logic                  net_done,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Head is held in 4 bits so that it can represent NUM_LAYERS itself
  // (up to 8) when the final layer retires.
  localparam logic [3:0] LAST = 4'(NUM_LAYERS);

  state_t                state_q, state_d;
  logic [3:0]            head_q, head_d;
  logic                  pending_q, pending_d;
  logic [NUM_LAYERS-1:0] begin_d;
  logic                  busy_d;
  logic [2:0]            cur_d;
  logic                  done_d;

  logic [3:0]            head_p1;
  logic [3:0]            head_new;
  logic [3:0]            head_new_p1;
  logic                  head_cmp;
  logic                  next_cmp;

`ifdef LAYER_TIMEOUT_EN
  logic [15:0]           wdog_q, wdog_d;
  logic                  terr_d;
`endif

  // Next-state and output logic. A complete from the second in-flight layer
  // only counts while its begin is high, so an early complete cannot be seen
  // twice and completes from layers that are not yet active are ignored.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    pending_d   = pending_q;
    begin_d     = '0;
    busy_d      = 1'b0;
    cur_d       = 3'd0;
    done_d      = 1'b0;
    head_p1     = head_q + 4'd1;
    head_new    = head_q;
    head_new_p1 = head_q + 4'd1;
    head_cmp    = 1'b0;
    next_cmp    = 1'b0;
`ifdef LAYER_TIMEOUT_EN
    wdog_d      = wdog_q;
    terr_d      = timeout_err;
`endif

    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (4'(k) == head_q) begin
        head_cmp = layer_complete[k];
      end
      if (4'(k) == head_p1) begin
        next_cmp = layer_complete[k] & layer_begin[k];
      end
    end

    case (state_q)
      IDLE, ERR: begin
        head_d    = 4'd0;
        pending_d = 1'b0;
        if (start) begin
          // Only the first layer starts on entry. Its successor follows one
          // cycle later through the normal RUN path.
          state_d    = RUN;
          begin_d[0] = 1'b1;
          busy_d     = 1'b1;
`ifdef LAYER_TIMEOUT_EN
          wdog_d     = 16'd0;
          terr_d     = 1'b0;
`endif
        end
      end

      RUN: begin
        if (head_cmp) begin
          head_new  = (next_cmp || pending_q) ? head_q + 4'd2 : head_q + 4'd1;
          pending_d = 1'b0;
`ifdef LAYER_TIMEOUT_EN
          wdog_d    = 16'd0;
`endif
        end else begin
          pending_d = pending_q | next_cmp;
`ifdef LAYER_TIMEOUT_EN
          wdog_d    = wdog_q + 16'd1;
`endif
        end
        head_new_p1 = head_new + 4'd1;

        if (head_new >= LAST) begin
          state_d = IDLE;
          head_d  = 4'd0;
          done_d  = 1'b1;
        end else begin
          head_d = head_new;
          busy_d = 1'b1;
          cur_d  = head_new[2:0];
          // The successor stays dropped once it has already finished.
          for (int k = 0; k < NUM_LAYERS; k++) begin
            if (4'(k) == head_new || (4'(k) == head_new_p1 && !pending_d)) begin
              begin_d[k] = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = IDLE;
        head_d    = 4'd0;
        pending_d = 1'b0;
      end
    endcase

`ifdef LAYER_TIMEOUT_EN
    // The watchdog overrides any retire that happens in the same cycle.
    if (state_q == RUN && wdog_q >= TIMEOUT_CYCLES) begin
      state_d   = ERR;
      head_d    = 4'd0;
      pending_d = 1'b0;
      begin_d   = '0;
      busy_d    = 1'b0;
      cur_d     = 3'd0;
      done_d    = 1'b0;
      terr_d    = 1'b1;
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= 4'd0;
      pending_q   <= 1'b0;
      layer_begin <= '0;
      busy        <= 1'b0;
      cur_layer   <= 3'd0;
      net_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      pending_q   <= pending_d;
      layer_begin <= begin_d;
      busy        <= busy_d;
      cur_layer   <= cur_d;
      net_done    <= done_d;
    end
  end

`ifdef LAYER_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q      <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      timeout_err <= terr_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
